// File: rtl/rns_add_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit carry-lookahead adder between N_REQ residue channels.
// Latency: accept to rsp_valid is 2 cycles (mod 2^W), or 3 cycles when an end-around-carry pass runs.
// Backpressure: one op in flight; the result holds until rsp_ready, and no grant is issued until then.
// Optional build macro RNS_ADD_STATS_EN adds saturating stat_ops / stat_eac counters.
module rns_add_arbiter #(
  parameter int N_REQ = 3,
  parameter int WIDTH = 6,
  localparam int IDW  = $clog2(N_REQ)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req_valid,
  output logic [N_REQ-1:0]       req_ready,
  input  logic [N_REQ*WIDTH-1:0] req_a,
  input  logic [N_REQ*WIDTH-1:0] req_b,
  input  logic [N_REQ-1:0]       req_mod1,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [IDW-1:0]         rsp_id,
  output logic [WIDTH-1:0]       rsp_result,
  output logic                   rsp_cout
`ifdef RNS_ADD_STATS_EN
  ,
  output logic [15:0]            stat_ops,
  output logic [15:0]            stat_eac
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    EAC  = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t state;
  state_t next_state;

  // Latched operation and running result
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic             mod1_r;
  logic [IDW-1:0]   id_r;
  logic [WIDTH-1:0] sum_r;
  logic             cout_r;
  logic [IDW-1:0]   rr_ptr;

  // Arbiter results
  logic [N_REQ-1:0] grant;
  logic             grant_any;
  logic [IDW-1:0]   grant_id;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic             sel_mod1;
  logic             accept;

  // Shared adder core
  logic [WIDTH-1:0] core_x;
  logic [WIDTH-1:0] core_y;
  logic             core_cin;
  logic [WIDTH-1:0] core_sum;
  logic             core_cout;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;

  // Round-robin search from rr_ptr upward with wrap; first valid requester wins
  always_comb begin
    int idx;
    idx       = 0;
    grant     = '0;
    grant_any = 1'b0;
    grant_id  = '0;
    sel_a     = '0;
    sel_b     = '0;
    sel_mod1  = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= N_REQ) begin
        idx = idx - N_REQ;
      end
      if (!grant_any && req_valid[idx]) begin
        grant_any  = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = IDW'(idx);
        sel_a      = req_a[idx*WIDTH +: WIDTH];
        sel_b      = req_b[idx*WIDTH +: WIDTH];
        sel_mod1   = req_mod1[idx];
      end
    end
  end

  // Handshake can only happen in IDLE, where req_ready mirrors the grant
  assign accept = (state == IDLE) && grant_any;

  // Operand mux: first pass adds a+b, end-around pass adds the carry back into the sum
  always_comb begin
    core_x   = a_r;
    core_y   = b_r;
    core_cin = 1'b0;
    if (state == EAC) begin
      core_x   = sum_r;
      core_y   = '0;
      core_cin = 1'b1;
    end
  end

  // Flattened carry-lookahead: each carry is a sum of generate terms gated by propagate chains
  always_comb begin
    logic term;
    logic acc;
    term  = 1'b0;
    acc   = 1'b0;
    gen   = core_x & core_y;
    prop  = core_x ^ core_y;
    carry = '0;
    carry[0] = core_cin;
    for (int i = 0; i < WIDTH; i++) begin
      term = core_cin;
      for (int j = 0; j <= i; j++) begin
        term = term & prop[j];
      end
      acc = term;
      for (int j = 0; j <= i; j++) begin
        term = gen[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & prop[k];
        end
        acc = acc | term;
      end
      carry[i+1] = acc;
    end
    core_sum  = prop ^ carry[WIDTH-1:0];
    core_cout = carry[WIDTH];
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // FSM next state and handshake outputs
  always_comb begin
    next_state = state;
    req_ready  = '0;
    rsp_valid  = 1'b0;
    case (state)
      IDLE: begin
        req_ready = grant;
        if (grant_any) begin
          next_state = ADD;
        end
      end
      ADD: begin
        // A carry out of the first pass only matters for the mod 2^W-1 case
        if (mod1_r && core_cout) begin
          next_state = EAC;
        end else begin
          next_state = HOLD;
        end
      end
      EAC: begin
        next_state = HOLD;
      end
      HOLD: begin
        rsp_valid = 1'b1;
        if (rsp_ready) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Operation capture, pointer advance and adder result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r    <= '0;
      b_r    <= '0;
      mod1_r <= 1'b0;
      id_r   <= '0;
      sum_r  <= '0;
      cout_r <= 1'b0;
      rr_ptr <= '0;
    end else begin
      if (accept) begin
        a_r    <= sel_a;
        b_r    <= sel_b;
        mod1_r <= sel_mod1;
        id_r   <= grant_id;
        if (grant_id == IDW'(N_REQ - 1)) begin
          rr_ptr <= '0;
        end else begin
          rr_ptr <= grant_id + IDW'(1);
        end
      end
      if (state == ADD) begin
        sum_r  <= core_sum;
        cout_r <= core_cout;
      end
      // The end-around pass cannot carry out again, so only the sum is updated
      if (state == EAC) begin
        sum_r <= core_sum;
      end
    end
  end

  // All-ones is the second encoding of zero in mod 2^W-1; present it as 0
  assign rsp_result = (mod1_r && (&sum_r)) ? '0 : sum_r;
  assign rsp_id     = id_r;
  assign rsp_cout   = cout_r;

`ifdef RNS_ADD_STATS_EN
  // Saturating counters of completed responses and end-around-carry passes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_ops <= '0;
      stat_eac <= '0;
    end else begin
      if (rsp_valid && rsp_ready && (stat_ops != 16'hFFFF)) begin
        stat_ops <= stat_ops + 16'd1;
      end
      if ((state == EAC) && (stat_eac != 16'hFFFF)) begin
        stat_eac <= stat_eac + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rns_add_arbiter.sv
// Scoreboard bench for rns_add_arbiter: directed operations push expected responses,
// an independent monitor compares every presented response against the queue head.
module tb_rns_add_arbiter;
  localparam int N = 3;
  localparam int W = 6;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic [N-1:0]   req_mod1;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [1:0]     rsp_id;
  logic [W-1:0]   rsp_result;
  logic           rsp_cout;
`ifdef RNS_ADD_STATS_EN
  logic [15:0]    stat_ops;
  logic [15:0]    stat_eac;
`endif

  typedef struct packed {
    logic [1:0]   id;
    logic [W-1:0] res;
    logic         cout;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;

  rns_add_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_mod1   (req_mod1),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_cout   (rsp_cout)
`ifdef RNS_ADD_STATS_EN
    ,
    .stat_ops   (stat_ops),
    .stat_eac   (stat_eac)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] id, input logic [W-1:0] res, input logic cout);
    exp_t e;
    e.id   = id;
    e.res  = res;
    e.cout = cout;
    sb.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b, input logic m);
    req_valid[i]       = 1'b1;
    req_a[i*W +: W]    = a;
    req_b[i*W +: W]    = b;
    req_mod1[i]        = m;
  endtask

  // Wait (bounded) for any grant, then compare the one-hot grant vector
  task automatic grant_wait(input logic [N-1:0] exp_rdy, input string name, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while ((req_ready == '0) && (cyc < 20));
    check(name, req_ready, exp_rdy);
  endtask

  // Drop the granted request after the handshake edge and measure accept-to-valid latency
  task automatic wait_rsp(input logic [N-1:0] clr, input int lat, input string name);
    int cyc;
    cyc = 0;
    @(posedge clk);
    #1;
    req_valid = req_valid & ~clr;
    do begin
      @(negedge clk);
      cyc++;
    end while (!rsp_valid && (cyc < 20));
    check(name, cyc, lat);
  endtask

  task automatic drain(input string name);
    int cyc;
    cyc = 0;
    while ((sb.size() != 0) && (cyc < 20)) begin
      @(negedge clk);
      cyc++;
    end
    check(name, sb.size(), 0);
  endtask

  // Monitor: every cycle a response is shown it must match the queue head; pop on handshake
  always @(negedge clk) begin
    if (rst_n && rsp_valid) begin
      check("no_grant_in_hold", req_ready, 0);
      if (sb.size() == 0) begin
        check("unexpected_rsp", rsp_valid, 0);
      end else begin
        check("rsp_id", rsp_id, sb[0].id);
        check("rsp_result", rsp_result, sb[0].res);
        check("rsp_cout", rsp_cout, sb[0].cout);
        if (rsp_ready) begin
          void'(sb.pop_front());
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int   c;
    int   ord[4];
    int   gap[4];
    exp_t t4_exp[3];

    rst_n     = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_mod1  = '0;
    rsp_ready = 1'b1;

    repeat (2) @(negedge clk);
    check("reset_req_ready", req_ready, 0);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_id", rsp_id, 0);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_rsp_cout", rsp_cout, 0);
`ifdef RNS_ADD_STATS_EN
    check("reset_stat_ops", stat_ops, 0);
    check("reset_stat_eac", stat_eac, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Plain mod 2^6: 40+30 = 70 -> 6 with carry
    set_req(0, 6'd40, 6'd30, 1'b0);
    grant_wait(3'b001, "t1_grant", c);
    push(2'd0, 6'd6, 1'b1);
    wait_rsp(3'b001, 2, "t1_latency");

    // mod 63 with end-around carry: 70 -> 6 + 1 = 7
    @(posedge clk);
    #1;
    set_req(1, 6'd40, 6'd30, 1'b1);
    grant_wait(3'b010, "t2_grant", c);
    push(2'd1, 6'd7, 1'b1);
    wait_rsp(3'b010, 3, "t2_latency");

    // mod 63: 30+33 = 63 = all-ones -> normalised 0, no EAC
    @(posedge clk);
    #1;
    set_req(2, 6'd30, 6'd33, 1'b1);
    grant_wait(3'b100, "t3_grant", c);
    push(2'd2, 6'd0, 1'b0);
    wait_rsp(3'b100, 2, "t3_latency");

    // All requesters held valid: order 0,1,2,0; gaps 3 after a plain op, 4 after an EAC op
    @(posedge clk);
    #1;
    set_req(0, 6'd1, 6'd2, 1'b0);
    set_req(1, 6'd63, 6'd63, 1'b1);
    set_req(2, 6'd50, 6'd20, 1'b0);
    ord = '{0, 1, 2, 0};
    gap = '{0, 3, 4, 3};
    t4_exp[0] = '{id: 2'd0, res: 6'd3, cout: 1'b0};
    t4_exp[1] = '{id: 2'd1, res: 6'd0, cout: 1'b1};
    t4_exp[2] = '{id: 2'd2, res: 6'd6, cout: 1'b1};
    for (int n = 0; n < 4; n++) begin
      grant_wait(3'(1 << ord[n]), "t4_order", c);
      if (n > 0) begin
        check("t4_gap", c, gap[n]);
      end
      sb.push_back(t4_exp[ord[n]]);
      @(posedge clk);
      #1;
      if (n == 3) begin
        req_valid = '0;
      end
    end
    drain("t4_drain");

    // Stall in HOLD for 5 cycles with req0 waiting; next grant one cycle after release
    @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    set_req(1, 6'd5, 6'd7, 1'b0);
    set_req(0, 6'd1, 6'd1, 1'b0);
    grant_wait(3'b010, "t5_grant", c);
    push(2'd1, 6'd12, 1'b0);
    wait_rsp(3'b010, 2, "t5_latency");
    repeat (4) @(negedge clk);
    @(posedge clk);
    #1;
    rsp_ready = 1'b1;
    grant_wait(3'b001, "t5_regrant", c);
    check("t5_regrant_gap", c, 2);
    push(2'd0, 6'd2, 1'b0);
    wait_rsp(3'b001, 2, "t5_latency2");

    // Reset while the end-around pass is running
    @(posedge clk);
    #1;
    set_req(1, 6'd40, 6'd30, 1'b1);
    grant_wait(3'b010, "t6_grant", c);
    @(posedge clk);
    #1;
    req_valid = '0;
    @(negedge clk);
    @(negedge clk);
`ifdef RNS_ADD_STATS_EN
    check("t6_stat_ops_before", stat_ops, 9);
    check("t6_stat_eac_before", stat_eac, 2);
`endif
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rsp_valid", rsp_valid, 0);
    check("t6_req_ready", req_ready, 0);
    check("t6_rsp_id", rsp_id, 0);
    check("t6_rsp_result", rsp_result, 0);
`ifdef RNS_ADD_STATS_EN
    check("t6_stat_ops", stat_ops, 0);
    check("t6_stat_eac", stat_eac, 0);
`endif
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // rr_ptr was 2 before reset; req0 must win over req1 now. 63+0 mod 63 -> 0
    set_req(1, 6'd9, 6'd9, 1'b0);
    set_req(0, 6'd63, 6'd0, 1'b1);
    grant_wait(3'b001, "t6_rr_after_reset", c);
    push(2'd0, 6'd0, 1'b0);
    wait_rsp(3'b011, 2, "t6_latency");
    drain("t6_drain");
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
